seq_pattern_gen: RTL and testbench

- Serial pattern transmitter; the driving end of the serial bit-sequence interface consumed by the team's Mealy sequence detectors.
- Holds a WIDTH-bit pattern and shifts it out MSB-first on dout, one bit per clk, for a programmed number of repetitions.
- Optional idle gap of zeros between repetitions.
- Used as an on-chip stimulus source and as a loopback source for detector self-test.

---
 rtl/seq_pattern_gen.sv | 92 +++++++++
 tb/tb_seq_pattern_gen.sv | 121 ++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial MSB-first pattern transmitter with repetition count and optional zero gap
module seq_pattern_gen #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8,
    parameter int               GAP     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] pat_in,
    input  logic             start,
    input  logic [CNT_W-1:0] rep_in,
    input  logic             abort,
    output logic             dout,
    output logic             dvalid,
    output logic             busy,
    output logic             done
);
    localparam int IW = $clog2(WIDTH);
    localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, GAPS} state_t;
    state_t           state;
    logic [WIDTH-1:0] pat;
    logic [IW-1:0]    idx;
    logic [CNT_W-1:0] reps;
    logic [GW-1:0]    gcnt;
    logic             fin;
    // dout lags the state by one cycle, so done is raised from fin once the last bit has been shown
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state  <= IDLE;
            pat    <= PATTERN;
            idx    <= '0;
            reps   <= '0;
            gcnt   <= '0;
            fin    <= 1'b0;
            dout   <= 1'b0;
            dvalid <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (abort) begin
            state  <= IDLE;
            fin    <= 1'b0;
            dout   <= 1'b0;
            dvalid <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            dout   <= 1'b0;
            dvalid <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    fin  <= 1'b0;
                    done <= fin;
                    if (load) pat <= pat_in;
                    if (start && !fin) begin
                        if (rep_in == '0) done <= 1'b1;
                        else begin
                            reps  <= rep_in;
                            idx   <= IW'(WIDTH - 1);
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    dout   <= pat[idx];
                    dvalid <= 1'b1;
                    if (idx != '0) idx <= idx - 1'b1;
                    else begin
                        reps <= reps - 1'b1;
                        idx  <= IW'(WIDTH - 1);
                        if (reps == CNT_W'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            fin   <= 1'b1;
                        end else if (GAP > 0) begin
                            state <= GAPS;
                            gcnt  <= GW'(GAP > 0 ? GAP - 1 : 0);
                        end
                    end
                end
                GAPS: begin
                    if (gcnt == '0) state <= SHIFT;
                    else gcnt <= gcnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: table-driven runs on a GAP=0 and a GAP=2 instance, checked cycle by cycle via expected-output queues
module tb_seq_pattern_gen;
    logic clk = 1'b0, reset = 1'b1, load = 1'b0, start = 1'b0, abort = 1'b0;
    logic [3:0] pat_in = '0;
    logic [7:0] rep_in = '0;
    logic dout0, dvalid0, busy0, done0, dout2, dvalid2, busy2, done2;
    logic [3:0] q0[$], q2[$];
    int checks = 0, errors = 0;

    typedef struct {
        logic       ld;
        logic [3:0] pin;
        int         reps;
        int         cut;
        logic [3:0] ep;
        logic       bl;
    } vec_t;
    vec_t tv[9];

    seq_pattern_gen #(.GAP(0)) d0 (.clk(clk), .reset(reset), .load(load), .pat_in(pat_in), .start(start),
        .rep_in(rep_in), .abort(abort), .dout(dout0), .dvalid(dvalid0), .busy(busy0), .done(done0));
    seq_pattern_gen #(.GAP(2)) d2 (.clk(clk), .reset(reset), .load(load), .pat_in(pat_in), .start(start),
        .rep_in(rep_in), .abort(abort), .dout(dout2), .dvalid(dvalid2), .busy(busy2), .done(done2));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [3:0] a, input logic [3:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s {dout,dvalid,busy,done} got %b exp %b at %0t", n, a, e, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (reset && q0.size() > 0) chk("gap0", {dout0, dvalid0, busy0, done0}, q0.pop_front());
        if (reset && q2.size() > 0) chk("gap2", {dout2, dvalid2, busy2, done2}, q2.pop_front());
    end

    // Expected per-cycle outputs from the cycle after start is sampled; cut>0 models an abort after cut entries
    task automatic push_run(input int g, input logic [3:0] p, input int reps, input int cut);
        logic [3:0] s[$];
        if (reps == 0) s.push_back(4'b0001);
        else begin
            s.push_back(4'b0010);
            for (int r = 1; r <= reps; r++) begin
                for (int i = 3; i >= 0; i--) s.push_back({p[i], 1'b1, !(r == reps && i == 0), 1'b0});
                if (r < reps) for (int j = 0; j < g; j++) s.push_back(4'b0010);
            end
            s.push_back(4'b0001);
        end
        s.push_back(4'b0000);
        if (cut > 0) begin
            while (s.size() > cut) void'(s.pop_back());
            repeat (3) s.push_back(4'b0000);
        end
        foreach (s[i]) if (g == 0) q0.push_back(s[i]); else q2.push_back(s[i]);
    endtask

    task automatic run(input vec_t v);
        @(negedge clk);
        load = v.ld; pat_in = v.pin; start = 1'b1; rep_in = 8'(v.reps);
        push_run(0, v.ep, v.reps, v.cut);
        push_run(2, v.ep, v.reps, v.cut);
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        if (v.cut > 0) begin
            repeat (v.cut - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        if (v.bl) begin
            @(negedge clk);
            load = 1'b1; pat_in = 4'hf; start = 1'b1; rep_in = 8'd5;
            @(negedge clk);
            load = 1'b0; start = 1'b0;
        end
        for (int t = 0; t < 200 && (q0.size() > 0 || q2.size() > 0); t++) @(negedge clk);
        checks++;
        if (q0.size() > 0 || q2.size() > 0) begin
            errors++;
            $display("FAIL drain timeout left q0=%0d q2=%0d required 0", q0.size(), q2.size());
            q0.delete();
            q2.delete();
        end
    endtask

    initial begin
        tv[0] = '{1'b0, 4'h0, 1, 0, 4'b1011, 1'b0};
        tv[1] = '{1'b0, 4'h0, 3, 0, 4'b1011, 1'b0};
        tv[2] = '{1'b0, 4'h0, 2, 0, 4'b1011, 1'b0};
        tv[3] = '{1'b1, 4'b0110, 1, 0, 4'b0110, 1'b1};
        tv[4] = '{1'b0, 4'h0, 2, 0, 4'b0110, 1'b0};
        tv[5] = '{1'b0, 4'h0, 3, 7, 4'b0110, 1'b0};
        tv[6] = '{1'b0, 4'h0, 1, 0, 4'b0110, 1'b0};
        tv[7] = '{1'b1, 4'b1100, 0, 0, 4'b0000, 1'b0};
        tv[8] = '{1'b0, 4'h0, 1, 0, 4'b1100, 1'b0};
        #1 reset = 1'b0;
        #2;
        chk("reset0", {dout0, dvalid0, busy0, done0}, 4'b0000);
        chk("reset2", {dout2, dvalid2, busy2, done2}, 4'b0000);
        @(negedge clk) reset = 1'b1;
        foreach (tv[i]) run(tv[i]);
        @(negedge clk);
        start = 1'b1; rep_in = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("async_reset0", {dout0, dvalid0, busy0, done0}, 4'b0000);
        chk("async_reset2", {dout2, dvalid2, busy2, done2}, 4'b0000);
        @(negedge clk) reset = 1'b1;
        run('{1'b0, 4'h0, 0, 0, 4'b0000, 1'b0});
        run('{1'b0, 4'h0, 1, 0, 4'b1011, 1'b0});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
